// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_t;

    localparam int DATA_BITS             = 8;
    localparam int STOP_BITS             = 1;
    localparam int DEFAULT_CLOCK_PER_BIT = 50;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == {CNT_W{1'b0}});
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr <= do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr <= do_pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end else begin
            mem[wr_ptr] <= mem[wr_ptr];
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: buffered valid/ready byte input, LSB-first serialisation,
// one idle-high CLEANUP cycle after each stop bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [7:0]                    data_in_tx,
    output logic                          tx_ready,
    output logic                          serial_output,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int               CNT_W    = $clog2(CLOCK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic [2:0]           bit_index;
    logic [2:0]           bit_index_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 at_last;
    logic                 serial_next;
    logic                 done_next;

    assign tx_ready = !rst && !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign at_last  = (bit_cnt == CNT_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in_tx),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // State, counters, byte holding register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= {CNT_W{1'b0}};
            bit_index     <= 3'd0;
            shift_reg     <= {DATA_BITS{1'b0}};
            serial_output <= 1'b1;
            tx_done       <= 1'b0;
            tx_busy       <= 1'b0;
        end else begin
            state         <= state_next;
            bit_cnt       <= bit_cnt_next;
            bit_index     <= bit_index_next;
            shift_reg     <= pop ? fifo_head : shift_reg;
            serial_output <= serial_next;
            tx_done       <= done_next;
            tx_busy       <= (state != IDLE);
        end
    end

    // Next-state and counter logic; the bit counter restarts at every bit boundary.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = {CNT_W{1'b0}};
        bit_index_next = bit_index;
        case (state)
            IDLE: begin
                bit_index_next = 3'd0;
                if (!fifo_empty) begin
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (at_last) begin
                    state_next = DATA;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (!at_last) begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end else if (bit_index == LAST_BIT) begin
                    state_next = STOP;
                end else begin
                    bit_index_next = bit_index + 3'd1;
                end
            end
            STOP: begin
                if (at_last) begin
                    state_next = CLEANUP;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            CLEANUP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: FIFO pop, next line level and the end-of-stop-bit pulse.
    always_comb begin
        pop         = 1'b0;
        serial_next = 1'b1;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    serial_next = 1'b0;
                end else begin
                    serial_next = 1'b1;
                end
            end
            START: begin
                if (at_last) begin
                    serial_next = shift_reg[0];
                end else begin
                    serial_next = 1'b0;
                end
            end
            DATA: begin
                if (at_last && (bit_index == LAST_BIT)) begin
                    serial_next = 1'b1;
                end else begin
                    serial_next = shift_reg[bit_index_next];
                end
            end
            STOP: begin
                serial_next = 1'b1;
                done_next   = at_last;
            end
            CLEANUP: serial_next = 1'b1;
            default: serial_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed, table-driven bench for uart_transmitter with a loopback receiver model.
module tb_uart_transmitter;
    localparam int CPB    = 4;
    localparam int CPB_L  = 50;
    localparam int DEPTH  = 4;
    localparam int N_LOOP = 48;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] = start bit slot, line[9] = stop bit slot
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tx_valid, tx_ready, serial_output, tx_busy, tx_done;
    logic [7:0] data_in_tx;
    logic [2:0] fifo_count;

    logic       rst_l, tx_valid_l, tx_ready_l, serial_output_l, tx_busy_l, tx_done_l;
    logic [7:0] data_in_tx_l;
    logic [2:0] fifo_count_l;

    int checks = 0;
    int errors = 0;
    logic [7:0] sent_q [$];

    uart_transmitter #(.CLOCK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .data_in_tx(data_in_tx),
        .tx_ready(tx_ready), .serial_output(serial_output), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_transmitter #(.CLOCK_PER_BIT(CPB_L), .FIFO_DEPTH(DEPTH)) dut_l (
        .clk(clk), .rst(rst_l), .tx_valid(tx_valid_l), .data_in_tx(data_in_tx_l),
        .tx_ready(tx_ready_l), .serial_output(serial_output_l), .tx_busy(tx_busy_l),
        .tx_done(tx_done_l), .fifo_count(fifo_count_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called with the frame's start edge as the next edge; ends two edges after tx_done.
    task automatic check_frame(input string name, input logic [9:0] line);
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < CPB; c++) begin
                step();
                check(name, {tx_done, serial_output}, {1'b0, line[s]});
            end
        end
        step();
        check({name, "_done"}, {tx_done, serial_output}, 2'b11);
        step();
        check({name, "_cleanup"}, {tx_done, serial_output}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t single [3];
        vec_t burst [5];
        vec_t full_seq [6];

        single[0]   = '{8'hA5, 10'b1101001010};
        single[1]   = '{8'h3C, 10'b1001111000};
        single[2]   = '{8'h01, 10'b1000000010};
        burst[0]    = '{8'h00, 10'b1000000000};
        burst[1]    = '{8'hFF, 10'b1111111110};
        burst[2]    = '{8'h55, 10'b1010101010};
        burst[3]    = '{8'h0F, 10'b1000011110};
        burst[4]    = '{8'h81, 10'b1100000010};
        full_seq[0] = '{8'h11, 10'b1000100010};
        full_seq[1] = '{8'h22, 10'b1001000100};
        full_seq[2] = '{8'h33, 10'b1001100110};
        full_seq[3] = '{8'h44, 10'b1010001000};
        full_seq[4] = '{8'h66, 10'b1011001100};
        full_seq[5] = '{8'h77, 10'b1011101110};

        // Reset and idle
        rst = 1'b1; tx_valid = 1'b0; data_in_tx = 8'h00;
        rst_l = 1'b1; tx_valid_l = 1'b0; data_in_tx_l = 8'h00;
        step();
        step();
        check("rst_outputs", {serial_output, tx_busy, tx_done, fifo_count}, 6'b100000);
        check("rst_ready", tx_ready, 32'd0);
        rst = 1'b0; rst_l = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle", {serial_output, tx_ready, tx_busy, tx_done, fifo_count}, 7'b1100000);
        end

        // Single frames from the vector table
        for (int i = 0; i < 3; i++) begin
            data_in_tx = single[i].data;
            tx_valid   = 1'b1;
            step();
            tx_valid   = 1'b0;
            data_in_tx = ~single[i].data;
            check("push_count", fifo_count, 32'd1);
            check("push_line_idle", serial_output, 32'd1);
            check_frame("single", single[i].line);
            check("busy_in_cleanup", tx_busy, 32'd1);
            step();
            check("busy_idle", tx_busy, 32'd0);
        end

        // Burst of five bytes into a four-deep FIFO
        data_in_tx = burst[0].data;
        tx_valid   = 1'b1;
        step();
        check("burst_first_count", fifo_count, 32'd1);
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    data_in_tx = burst[i].data;
                    step();
                    check("burst_count", fifo_count, i);
                end
                check("burst_full_ready", tx_ready, 32'd0);
                tx_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    check_frame("burst", burst[i].line);
                end
            end
        join
        step();

        // Hold tx_valid while full: accepted only after the next pop frees a slot
        data_in_tx = full_seq[0].data;
        tx_valid   = 1'b1;
        step();
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    data_in_tx = full_seq[i].data;
                    step();
                end
                data_in_tx = full_seq[5].data;
                for (int c = 0; c < 38; c++) begin
                    step();
                    check("full_hold", {fifo_count, tx_ready}, {3'd4, 1'b0});
                end
                step();
                check("full_pop", {fifo_count, tx_ready}, {3'd3, 1'b1});
                step();
                check("full_push", fifo_count, 32'd4);
                tx_valid   = 1'b0;
                data_in_tx = 8'h00;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    check_frame("full", full_seq[i].line);
                end
            end
        join
        step();

        // Reset during DATA bit 3 with a byte still queued
        data_in_tx = 8'h5A;
        tx_valid   = 1'b1;
        step();
        data_in_tx = 8'h99;
        step();
        tx_valid = 1'b0;
        check("rst_mid_count", fifo_count, 32'd1);
        for (int c = 0; c < 17; c++) begin
            step();
        end
        check("rst_mid_bit3", {tx_busy, serial_output}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid", {serial_output, tx_busy, tx_done, fifo_count}, 6'b100000);
        for (int c = 0; c < 60; c++) begin
            step();
            check("rst_quiet", {serial_output, tx_done, tx_busy}, 3'b100);
        end
        data_in_tx = 8'h3C;
        tx_valid   = 1'b1;
        step();
        tx_valid = 1'b0;
        check("post_rst_count", fifo_count, 32'd1);
        check_frame("post_rst", 10'b1001111000);
        step();

        // Loopback into a receiver model at CLOCK_PER_BIT=50
        fork
            begin
                for (int n = 0; n < N_LOOP; n++) begin
                    logic [7:0] byte_v;
                    int         budget;
                    byte_v       = 8'($urandom_range(0, 255));
                    data_in_tx_l = byte_v;
                    tx_valid_l   = 1'b1;
                    budget       = 0;
                    while (!tx_ready_l && budget < 2000) begin
                        step();
                        budget++;
                    end
                    check("loop_ready", tx_ready_l, 32'd1);
                    if (!tx_ready_l) break;
                    sent_q.push_back(byte_v);
                    step();
                end
                tx_valid_l = 1'b0;
            end
            begin
                for (int n = 0; n < N_LOOP; n++) begin
                    logic [7:0] rx;
                    int         wait_c;
                    wait_c = 0;
                    while (serial_output_l && wait_c < 3000) begin
                        step();
                        wait_c++;
                    end
                    check("loop_start_seen", serial_output_l, 32'd0);
                    if (serial_output_l) break;
                    repeat (CPB_L / 2) step();
                    check("loop_start_mid", serial_output_l, 32'd0);
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB_L) step();
                        rx[k] = serial_output_l;
                    end
                    repeat (CPB_L) step();
                    check("loop_stop", serial_output_l, 32'd1);
                    check("loop_queue_nonempty", (sent_q.size() != 0), 32'd1);
                    if (sent_q.size() != 0) begin
                        check("loop_byte", rx, sent_q.pop_front());
                    end
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
